mem_responder: RTL and testbench

//  Memory-side responder for core load/store/fetch traffic: accepts one request via valid/ready,

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_mem_array.sv | 35 +++
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and
// default bus geometry (four byte lanes per word).
package mem_responder_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-organised storage with per-byte-lane write enables; the addressed word
// is presented combinationally so the responder can capture it on the commit edge.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_WORDS = 16384,
  parameter int IDX_W       = 14
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [IDX_W-1:0]     idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  localparam int LANE_W = DATA_W / NUM_LANES;

  logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

  // Byte-lane write: lanes whose enable is low keep their stored value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_en[i]) begin
          mem_r[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder: one outstanding request, programmable wait
// states between acceptance and commit, byte-strobed writes, error on out-of-range words.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [NUM_LANES-1:0] req_strb,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err
);

  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WIDX_W = ADDR_W - 2;

  state_t               state_r;
  logic [3:0]           cnt_r;
  logic                 we_r;
  logic [WIDX_W-1:0]    widx_r;
  logic [DATA_W-1:0]    wdata_r;
  logic [NUM_LANES-1:0] strb_r;

  logic                 c_we_s;
  logic [WIDX_W-1:0]    c_widx_s;
  logic [DATA_W-1:0]    c_wdata_s;
  logic [NUM_LANES-1:0] c_strb_s;
  logic [31:0]          word_idx_s;
  logic [IDX_W-1:0]     ram_idx_s;
  logic                 commit_s;
  logic                 in_range_s;
  logic                 ram_we_s;
  logic [DATA_W-1:0]    ram_rdata_s;
  logic [DATA_W-1:0]    commit_rdata_s;
  logic                 addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^req_addr[1:0];

  // Commit operands: with zero wait states the commit happens on the accept edge,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      c_we_s    = req_we;
      c_widx_s  = req_addr[ADDR_W-1:2];
      c_wdata_s = req_wdata;
      c_strb_s  = req_strb;
    end else begin
      c_we_s    = we_r;
      c_widx_s  = widx_r;
      c_wdata_s = wdata_r;
      c_strb_s  = strb_r;
    end
  end

  // Commit point: accept edge when there are no wait states, else the last wait cycle.
  always_comb begin
    if (state_r == ST_IDLE) begin
      commit_s = req_valid && (WAIT_CYCLES == 0);
    end else if (state_r == ST_WAIT) begin
      commit_s = (cnt_r == 4'd1);
    end else begin
      commit_s = 1'b0;
    end
  end

  assign word_idx_s     = 32'(c_widx_s);
  assign in_range_s     = (word_idx_s < 32'(DEPTH_WORDS));
  assign ram_idx_s      = IDX_W'(c_widx_s);
  assign ram_we_s       = rst && commit_s && c_we_s && in_range_s;
  assign commit_rdata_s = (in_range_s && !c_we_s) ? ram_rdata_s : {DATA_W{1'b0}};

  mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .lane_en (c_strb_s),
    .idx     (ram_idx_s),
    .wdata   (c_wdata_s),
    .rdata   (ram_rdata_s)
  );

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      widx_r     <= {WIDX_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      strb_r     <= {NUM_LANES{1'b0}};
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
      resp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r      <= req_we;
            widx_r    <= req_addr[ADDR_W-1:2];
            wdata_r   <= req_wdata;
            strb_r    <= req_strb;
            cnt_r     <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            if (commit_s) begin
              state_r    <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= !in_range_s;
              resp_rdata <= commit_rdata_s;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (commit_s) begin
            state_r    <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= !in_range_s;
            resp_rdata <= commit_rdata_s;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_r    <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: two responders (2 wait states / 256 words, and 0 wait states /
// full depth) share one stimulus driver selected by sel; a monitor checks every response.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_strb = 4'h0;
  logic        resp_ready = 1'b0;
  logic        sel = 1'b0;
  logic        hold = 1'b0;

  logic        v0, v1, rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        req_ready_m, resp_valid_m, resp_err_m;
  logic [31:0] resp_rdata_m;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  bit prev_v = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_edge;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl[int];

  assign v0 = req_valid & ~sel;
  assign v1 = req_valid & sel;
  assign req_ready_m  = sel ? rdy1 : rdy0;
  assign resp_valid_m = sel ? rv1  : rv0;
  assign resp_rdata_m = sel ? rd1  : rd0;
  assign resp_err_m   = sel ? err1 : err0;

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(err0));

  mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH_WORDS(16384), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(err1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random response backpressure, changed between edges so the monitor sees a settled value.
  always @(posedge clk) begin
    #2;
    resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endfunction

  // Monitor: latency on each rising resp_valid, data/err on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (resp_valid_m === 1'b1) begin
        if (!prev_v && q.size() > 0)
          check("latency", 32'(cyc - q[0].acc_edge), sel ? 32'd0 : 32'd2);
        if (resp_ready) begin
          check("resp_pending", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("resp_rdata", resp_rdata_m, e.rdata);
            check("resp_err", 32'(resp_err_m), 32'(e.err));
          end
        end
      end
      prev_v = (resp_valid_m === 1'b1);
    end
  end

  // Issue one request (caller sits at a negedge); track=0 leaves model and scoreboard untouched.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input bit track);
    int guard;
    int idx;
    int key;
    int depth;
    logic [31:0] w;
    exp_t e;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_strb = st;
    while (req_ready_m !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("req_accept_timeout", 32'(req_ready_m), 32'd1);
    if (track) begin
      idx   = int'(addr[15:2]);
      depth = sel ? 16384 : 256;
      key   = (sel ? 65536 : 0) + idx;
      e.acc_edge = cyc + 1;
      e.rdata    = 32'h0;
      e.err      = (idx >= depth);
      if (!e.err) begin
        if (we) begin
          w = mdl.exists(key) ? mdl[key] : 32'h0;
          for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = wd[8*i +: 8];
          mdl[key] = w;
        end else begin
          e.rdata = mdl[key];
        end
      end
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pool_init();
    for (int i = 0; i < 8; i++) do_req(1'b1, 16'(i * 32), $urandom, 4'hF, 1'b1);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 9);
      if (op == 0 && sel == 1'b0) a = 16'(($urandom_range(256, 16383) << 2) | $urandom_range(0, 3));
      else                        a = 16'(($urandom_range(0, 7) * 32) | $urandom_range(0, 3));
      do_req(op < 5, a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready0", 32'(rdy0), 32'd1);
    check("rst_resp_valid0", 32'(rv0), 32'd0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_req_ready1", 32'(rdy1), 32'd1);
    check("rst_resp_valid1", 32'(rv1), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Responder with two wait states and 256 words.
    pool_init();
    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    do_req(1'b1, 16'h0010, 32'h000000AA, 4'b0001, 1'b1);
    do_req(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 1'b1);
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    drain();

    // Backpressure: response held, outputs stable, new requests refused.
    hold = 1'b1;
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    guard = 0;
    while (resp_valid_m !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 32'h0; req_strb = 4'hF;
      check("bp_valid", 32'(resp_valid_m), 32'd1);
      check("bp_rdata", resp_rdata_m, 32'hDEADBEAA);
      check("bp_req_ready", 32'(req_ready_m), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    hold = 1'b0;
    drain();
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);

    // Out-of-range word: error, no access, RAM untouched.
    do_req(1'b0, 16'h0400, 32'h0, 4'h0, 1'b1);
    do_req(1'b1, 16'h0400, 32'hCAFEF00D, 4'hF, 1'b1);
    do_req(1'b0, 16'h0000, 32'h0, 4'h0, 1'b1);

    // Reset during the wait states of a write drops it entirely.
    do_req(1'b1, 16'h0020, 32'h11111111, 4'hF, 1'b1);
    drain();
    do_req(1'b1, 16'h0020, 32'h22222222, 4'hF, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("mid_rst_req_ready", 32'(rdy0), 32'd1);
    check("mid_rst_resp_valid", 32'(rv0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_resp", 32'(rv0), 32'd0);
    end
    do_req(1'b0, 16'h0020, 32'h0, 4'h0, 1'b1);
    drain();
    rand_ops(80);
    drain();

    // Zero-wait-state responder with full depth.
    sel = 1'b1;
    @(negedge clk);
    pool_init();
    do_req(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
    do_req(1'b0, 16'h0010, 32'h0, 4'h0, 1'b1);
    do_req(1'b1, 16'h0400, 32'h12345678, 4'b1010, 1'b1);
    do_req(1'b0, 16'h0400, 32'h0, 4'h0, 1'b1);
    rand_ops(80);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
